// File: rtl/instr_fetch.sv
// instr_fetch: initiator side of the instruction-memory read interface.
// Owns the PC, issues one word-aligned read at a time, buffers the returned
// words in a small prefetch FIFO and hands {pc, instr} pairs to decode.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   mem_req, mem_addr          read request / byte address (held until mem_ack)
//   mem_ack, mem_instr         one-cycle response pulse and returned word
//   redirect_valid/_pc         one-cycle flush-and-refetch from execute
//   if_valid, if_ready         handshake to decode (pop on valid && ready)
//   if_instr, if_pc            FIFO head entry (zero when empty)
//
// Optional build macro FETCH_TRACE_EN: adds a fetched-instruction counter and
// $display tracing of accepted fetches and redirects. Ports and timing are
// unchanged.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle after reset, no request
// REQ   | request to pc outstanding (mem_req may be low for one cycle
//       | straight after a redirect)
// FULL  | FIFO full, no request; wait for decode to pop
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_pc_d    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_instr_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   count_after;
  logic            push;
  logic            pop;
  logic [31:0]     redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'h3;

  // An ack only counts against a live request; a redirect discards it.
  assign push = (state_q == REQ) && mem_req_q && mem_ack && !redirect_valid;
  assign pop  = (count_q != '0) && if_ready;

  always_comb begin
    count_after  = count_q + CW'(push) - CW'(pop);
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_after;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    if (push) begin
      fifo_pc_d[wr_ptr_q]    = pc_q;
      fifo_instr_d[wr_ptr_q] = mem_instr;
      wr_ptr_d               = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (redirect_valid) begin
      // Any outstanding request is dropped: mem_req goes low for one cycle
      // and comes back up at the new target.
      state_d    = REQ;
      pc_d       = redirect_tgt;
      mem_req_d  = 1'b0;
      mem_addr_d = redirect_tgt;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
        REQ: begin
          if (!mem_req_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end else if (push) begin
            pc_d       = pc_q + PC_STEP;
            mem_addr_d = pc_q + PC_STEP;
            if (count_after < DEPTH_C) begin
              mem_req_d = 1'b1;
            end else begin
              state_d   = FULL;
              mem_req_d = 1'b0;
            end
          end
        end
        FULL: begin
          if (pop) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign if_valid = (count_q != '0);
  // Head is forced to zero when empty so stale entries never leak out.
  assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;
  assign if_instr = if_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;

`ifdef FETCH_TRACE_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;

  assign fetch_cnt_d = fetch_cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else begin
      if (push) begin
        fetch_cnt_q <= fetch_cnt_d;
        $display("fetch: pc=%h instr=%h count=%0d time=%0t",
                 pc_q, mem_instr, fetch_cnt_d, $time);
      end
      if (redirect_valid) begin
        $display("redirect: pc=%h time=%0t", redirect_tgt, $time);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int errors = 0;
  int checks = 0;

  // memory responder state
  int          lat;
  int          age;
  logic        was_req;
  logic        acked_prev;
  logic [31:0] req_addr;

  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  logic [31:0] got_addr[$];

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_instr      (mem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   word = 32'h5800_0000;
      32'h4:   word = 32'h5808_0010;
      32'h8:   word = 32'h2000_0001;
      default: word = 32'hE000_0000 | a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Acks a request once it has been up for 'lat' cycles (lat=0: same cycle).
  task automatic respond();
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!was_req || acked_prev || mem_addr != req_addr) begin
        age      = 0;
        req_addr = mem_addr;
      end else begin
        age++;
      end
      if (age == lat) begin
        mem_ack   = 1'b1;
        mem_instr = word(mem_addr);
      end
      was_req    = 1'b1;
      acked_prev = mem_ack;
    end else begin
      was_req    = 1'b0;
      acked_prev = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    respond();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    mem_ack        = 1'b0;
    mem_instr      = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if_ready       = 1'b0;
    lat            = 0;
    age            = 0;
    was_req        = 1'b0;
    acked_prev     = 1'b0;
    req_addr       = 32'd0;

    // reset state
    do_reset();
    chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr,          32'd0);
    chk("rst_if_pc",    if_pc,             32'd0);

    // sequential fetch, ack 2 cycles after req
    lat      = 2;
    if_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (if_valid && if_ready) begin
        got_pc.push_back(if_pc);
        got_instr.push_back(if_instr);
      end
      if (mem_req && (got_addr.size() == 0 || mem_addr != got_addr[$]))
        got_addr.push_back(mem_addr);
    end
    chk("seq_pc0",    got_pc.size()    > 0 ? got_pc[0]    : 32'hDEAD_DEAD, 32'h0);
    chk("seq_instr0", got_instr.size() > 0 ? got_instr[0] : 32'hDEAD_DEAD, 32'h5800_0000);
    chk("seq_pc1",    got_pc.size()    > 1 ? got_pc[1]    : 32'hDEAD_DEAD, 32'h4);
    chk("seq_instr1", got_instr.size() > 1 ? got_instr[1] : 32'hDEAD_DEAD, 32'h5808_0010);
    chk("seq_pc2",    got_pc.size()    > 2 ? got_pc[2]    : 32'hDEAD_DEAD, 32'h8);
    chk("seq_instr2", got_instr.size() > 2 ? got_instr[2] : 32'hDEAD_DEAD, 32'h2000_0001);
    chk("seq_addr0",  got_addr.size()  > 0 ? got_addr[0]  : 32'hDEAD_DEAD, 32'h0);
    chk("seq_addr1",  got_addr.size()  > 1 ? got_addr[1]  : 32'hDEAD_DEAD, 32'h4);
    chk("seq_addr2",  got_addr.size()  > 2 ? got_addr[2]  : 32'hDEAD_DEAD, 32'h8);
    chk("seq_addr3",  got_addr.size()  > 3 ? got_addr[3]  : 32'hDEAD_DEAD, 32'hC);

    // backpressure, zero-wait memory
    do_reset();
    lat = 0;
    step();
    chk("bp_first_req",  {31'd0, mem_req}, 32'd1);
    chk("bp_first_addr", mem_addr,         32'h0);
    step();
    chk("bp_addr4", mem_addr, 32'h4);
    step();
    chk("bp_full_req", {31'd0, mem_req},  32'd0);
    chk("bp_valid",    {31'd0, if_valid}, 32'd1);
    chk("bp_head_pc",  if_pc,             32'h0);
    step();
    step();
    chk("bp_hold_req", {31'd0, mem_req}, 32'd0);
    chk("bp_hold_pc",  if_pc,            32'h0);
    chk("bp_hold_ins", if_instr,         32'h5800_0000);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("bp_refill_req",  {31'd0, mem_req}, 32'd1);
    chk("bp_refill_addr", mem_addr,         32'h8);
    chk("bp_next_pc",     if_pc,            32'h4);
    chk("bp_next_ins",    if_instr,         32'h5808_0010);
    step();
    chk("bp_full_again", {31'd0, mem_req}, 32'd0);

    // redirect mid-request
    do_reset();
    lat      = 1;
    if_ready = 1'b1;
    step(); step(); step(); step(); step();
    chk("rd_pre_req",  {31'd0, mem_req}, 32'd1);
    chk("rd_pre_addr", mem_addr,         32'h8);
    chk("rd_pre_pc",   if_pc,            32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush",    {31'd0, if_valid}, 32'd0);
    chk("rd_req_drop", {31'd0, mem_req},  32'd0);
    chk("rd_addr",     mem_addr,          32'h10);
    step();
    chk("rd_req_back", {31'd0, mem_req}, 32'd1);
    chk("rd_req_addr", mem_addr,         32'h10);
    step();
    chk("rd_no_pc8", {31'd0, if_valid}, 32'd0);
    step();
    chk("rd_new_pc",  if_pc,    32'h10);
    chk("rd_new_ins", if_instr, 32'hE000_0010);

    // redirect colliding with ack; low target bits forced to zero
    do_reset();
    lat      = 0;
    if_ready = 1'b1;
    step(); step(); step(); step();
    chk("col_pre_pc",   if_pc,    32'h8);
    chk("col_pre_addr", mem_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h23;
    step();
    redirect_valid = 1'b0;
    chk("col_flush", {31'd0, if_valid}, 32'd0);
    chk("col_addr",  mem_addr,          32'h20);
    step();
    chk("col_req", {31'd0, mem_req}, 32'd1);
    step();
    chk("col_pc0", if_pc, 32'h20);
    step();
    chk("col_pc1",  if_pc,    32'h24);
    chk("col_ins1", if_instr, 32'hE000_0024);

    // reset while a request to 8 is outstanding with one entry buffered
    do_reset();
    lat      = 1;
    if_ready = 1'b1;
    step(); step(); step(); step(); step();
    chk("mr_pre_addr",  mem_addr,          32'h8);
    chk("mr_pre_valid", {31'd0, if_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lat   = 0;
    chk("mr_req",   {31'd0, mem_req},  32'd0);
    chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_addr",  mem_addr,          32'h0);
    step();
    chk("mr_first_req",  {31'd0, mem_req}, 32'd1);
    chk("mr_first_addr", mem_addr,         32'h0);

    // PC wrap; the ack for addr 0 in the redirect cycle is discarded
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wr_addr",  mem_addr,          32'hFFFF_FFFC);
    chk("wr_empty", {31'd0, if_valid}, 32'd0);
    step();
    chk("wr_req", {31'd0, mem_req}, 32'd1);
    step();
    chk("wr_pc_top",  if_pc,    32'hFFFF_FFFC);
    chk("wr_addr0",   mem_addr, 32'h0);
    step();
    chk("wr_pc_zero", if_pc,    32'h0);
    chk("wr_ins_zero", if_instr, 32'h5800_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
